// File: rtl/lsu_data_mem.sv
// lsu_data_mem: byte-addressable data memory with a RISC-V load/store
// front end, valid/ready request handshake and configurable wait states.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready request handshake (ready only in IDLE, low in reset)
//   req_we          1 = store, 0 = load
//   req_funct3      RISC-V size/sign code (B, H, W, BU, HU)
//   req_addr        byte address
//   req_wdata       right-aligned store data
//   rsp_valid       one-cycle response strobe
//   rsp_rdata       extended load data (0 for stores and on errors)
//   rsp_err         access rejected (qualified by rsp_valid)
module lsu_data_mem #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] idx [4];
    logic [7:0]        rd_byte [4];
    logic [3:0]        byte_en;
    logic              bad_op;
    logic              misalign;
    logic              out_of_range;
    logic              acc_err;
    logic              access;
    logic              wr_en;
    logic [31:0]       load_data;

    // Byte lane i lives at addr+i, wrapping inside the storage.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            idx[i]     = addr_q[ADDR_W-1:0] + ADDR_W'(i);
            rd_byte[i] = mem[idx[i]];
        end
    end

    always_comb begin
        bad_op = 1'b0;
        case (funct3_q)
            3'b011, 3'b110, 3'b111: bad_op = 1'b1;
            3'b100, 3'b101:         bad_op = we_q;
            default:                bad_op = 1'b0;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        if (funct3_q[1:0] == 2'b01) begin
            misalign = addr_q[0];
        end else if (funct3_q[1:0] == 2'b10) begin
            misalign = (addr_q[1:0] != 2'b00);
        end
    end

    assign out_of_range = ((addr_q >> ADDR_W) != 32'd0);
    assign acc_err      = bad_op || misalign || out_of_range;

    always_comb begin
        byte_en = 4'b0000;
        case (funct3_q[1:0])
            2'b00:   byte_en = 4'b0001;
            2'b01:   byte_en = 4'b0011;
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        load_data = 32'd0;
        case (funct3_q)
            3'b000:  load_data = {{24{rd_byte[0][7]}}, rd_byte[0]};
            3'b001:  load_data = {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
            3'b010:  load_data = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
            3'b100:  load_data = {24'd0, rd_byte[0]};
            3'b101:  load_data = {16'd0, rd_byte[1], rd_byte[0]};
            default: load_data = 32'd0;
        endcase
    end

    assign access = (state_q == S_BUSY) && (cnt_q == 4'd0);
    // A reset landing in BUSY forces IDLE, so a pending store never lands.
    assign wr_en  = access && we_q && !acc_err && !rst;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d  = S_BUSY;
                    cnt_d    = 4'(WAIT_STATES);
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    err_d   = acc_err;
                    rdata_d = (acc_err || we_q) ? 32'd0 : load_data;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && byte_en[i]) begin
                mem[idx[i]] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// tb_lsu_data_mem: table-driven, hand-sequenced and randomized checks of
// lsu_data_mem at WAIT_STATES 0, 3 and 2 against a byte-array model.
module tb_lsu_data_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_v;
    logic [2:0]       req_valid_v;
    logic [2:0]       req_ready_v;
    logic [2:0]       req_we_v;
    logic [2:0][2:0]  f3_v;
    logic [2:0][31:0] addr_v;
    logic [2:0][31:0] wdata_v;
    logic [2:0]       rsp_valid_v;
    logic [2:0][31:0] rdata_v;
    logic [2:0]       rsp_err_v;

    lsu_data_mem #(.ADDR_W(12), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst_v[0]),
        .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
        .req_we(req_we_v[0]), .req_funct3(f3_v[0]),
        .req_addr(addr_v[0]), .req_wdata(wdata_v[0]),
        .rsp_valid(rsp_valid_v[0]), .rsp_rdata(rdata_v[0]),
        .rsp_err(rsp_err_v[0])
    );

    lsu_data_mem #(.ADDR_W(12), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst_v[1]),
        .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
        .req_we(req_we_v[1]), .req_funct3(f3_v[1]),
        .req_addr(addr_v[1]), .req_wdata(wdata_v[1]),
        .rsp_valid(rsp_valid_v[1]), .rsp_rdata(rdata_v[1]),
        .rsp_err(rsp_err_v[1])
    );

    lsu_data_mem #(.ADDR_W(12), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst_v[2]),
        .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
        .req_we(req_we_v[2]), .req_funct3(f3_v[2]),
        .req_addr(addr_v[2]), .req_wdata(wdata_v[2]),
        .rsp_valid(rsp_valid_v[2]), .rsp_rdata(rdata_v[2]),
        .rsp_err(rsp_err_v[2])
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mm [3][4096];
    bit         mw [3][4096];

    typedef struct {
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        bit        err;
    } vec_t;

    vec_t tbl [$];

    function automatic int ws_of(int d);
        if (d == 0) return 0;
        if (d == 1) return 3;
        return 2;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: legality rules, little-endian bytes, arithmetic extension.
    function automatic void model(int d, bit we, bit [2:0] f3,
                                  bit [31:0] a, bit [31:0] wd,
                                  output logic [31:0] r,
                                  output bit e, output bit known);
        int     sz;
        longint v;
        e = (f3 == 3 || f3 == 6 || f3 == 7)
            || (we && (f3 == 4 || f3 == 5))
            || ((f3 == 1 || f3 == 5) && (a % 2 != 0))
            || (f3 == 2 && (a % 4 != 0))
            || (a >= 4096);
        sz = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
        r = 32'd0;
        known = 1'b1;
        if (e) return;
        if (we) begin
            for (int i = 0; i < sz; i++) begin
                mm[d][a + i] = 8'(wd >> (8 * i));
                mw[d][a + i] = 1'b1;
            end
            return;
        end
        v = 0;
        for (int i = 0; i < sz; i++) begin
            if (!mw[d][a + i]) known = 1'b0;
            v = v + (longint'(mm[d][a + i]) << (8 * i));
        end
        if (f3 == 0 && v >= 128) v = v - 256;
        if (f3 == 1 && v >= 32768) v = v - 65536;
        r = v[31:0];
    endfunction

    task automatic accept(int d, bit we, bit [2:0] f3,
                          bit [31:0] a, bit [31:0] wd);
        int n = 0;
        @(negedge clk);
        req_valid_v[d] = 1'b1;
        req_we_v[d]    = we;
        f3_v[d]        = f3;
        addr_v[d]      = a;
        wdata_v[d]     = wd;
        #1;
        while (!req_ready_v[d] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid_v[d] = 1'b0;
    endtask

    task automatic txn(string tag, int d, bit we, bit [2:0] f3,
                       bit [31:0] a, bit [31:0] wd, bit poke,
                       logic [31:0] exp_r, bit exp_e, bit known);
        int lat = 1;
        int busy_rdy = 0;
        accept(d, we, f3, a, wd);
        while (!rsp_valid_v[d] && lat < 40) begin
            if (req_ready_v[d]) busy_rdy++;
            if (poke && lat == 2) begin
                req_valid_v[d] = 1'b1;
                req_we_v[d]    = 1'b1;
                f3_v[d]        = 3'b010;
                addr_v[d]      = 32'h44;
                wdata_v[d]     = 32'hBAD0BAD0;
            end
            if (poke && lat == 3) req_valid_v[d] = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (req_ready_v[d]) busy_rdy++;
        chk({tag, "_latency"}, 32'(lat), 32'(2 + ws_of(d)));
        chk({tag, "_ready_busy"}, 32'(busy_rdy), 32'd0);
        chk({tag, "_err"}, 32'(rsp_err_v[d]), 32'(exp_e));
        if (known) chk({tag, "_rdata"}, rdata_v[d], exp_r);
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(rsp_valid_v[d]), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready_v[d]), 32'd1);
        if (known) chk({tag, "_rdata_hold"}, rdata_v[d], exp_r);
        if (poke) begin
            repeat (3) begin
                @(negedge clk);
                chk({tag, "_no_queued"}, 32'(rsp_valid_v[d]), 32'd0);
            end
        end
    endtask

    task automatic txn_m(string tag, int d, bit we, bit [2:0] f3,
                         bit [31:0] a, bit [31:0] wd, bit poke);
        logic [31:0] r;
        bit e, k;
        model(d, we, f3, a, wd, r, e, k);
        txn(tag, d, we, f3, a, wd, poke, r, e, k);
    endtask

    function automatic void add(bit we, bit [2:0] f3, bit [31:0] a,
                                bit [31:0] wd, bit [31:0] r, bit e);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a;
        v.wdata = wd; v.rdata = r; v.err = e;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [31:0] r;
        bit e, k;
        rst_v       = 3'b111;
        req_valid_v = '0;
        req_we_v    = '0;
        f3_v        = '0;
        addr_v      = '0;
        wdata_v     = '0;

        add(1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0, 0);
        add(0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 0);
        add(1, 3'b000, 32'h011, 32'h0000007F, 32'h0, 0);
        add(0, 3'b010, 32'h010, 32'h0, 32'hDEAD7FEF, 0);
        add(0, 3'b000, 32'h013, 32'h0, 32'hFFFFFFDE, 0);
        add(0, 3'b100, 32'h013, 32'h0, 32'h000000DE, 0);
        add(0, 3'b001, 32'h012, 32'h0, 32'hFFFFDEAD, 0);
        add(0, 3'b101, 32'h012, 32'h0, 32'h0000DEAD, 0);
        add(0, 3'b010, 32'h012, 32'h0, 32'h0, 1);
        add(1, 3'b001, 32'h011, 32'h0000AAAA, 32'h0, 1);
        add(0, 3'b010, 32'h010, 32'h0, 32'hDEAD7FEF, 0);
        add(0, 3'b011, 32'h010, 32'h0, 32'h0, 1);
        add(1, 3'b100, 32'h010, 32'h00000055, 32'h0, 1);
        add(1, 3'b101, 32'h010, 32'h00005555, 32'h0, 1);
        add(0, 3'b110, 32'h010, 32'h0, 32'h0, 1);
        add(0, 3'b111, 32'h010, 32'h0, 32'h0, 1);
        add(0, 3'b010, 32'h1000, 32'h0, 32'h0, 1);
        add(1, 3'b010, 32'h1010, 32'h01234567, 32'h0, 1);
        add(1, 3'b010, 32'h80000010, 32'h89ABCDEF, 32'h0, 1);
        add(0, 3'b010, 32'h010, 32'h0, 32'hDEAD7FEF, 0);
        add(1, 3'b001, 32'h014, 32'h00008001, 32'h0, 0);
        add(0, 3'b001, 32'h014, 32'h0, 32'hFFFF8001, 0);
        add(0, 3'b000, 32'h015, 32'h0, 32'hFFFFFF80, 0);
        add(0, 3'b000, 32'h014, 32'h0, 32'h00000001, 0);

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", 32'(req_ready_v[d]), 32'd0);
            chk("rst_valid", 32'(rsp_valid_v[d]), 32'd0);
            chk("rst_rdata", rdata_v[d], 32'd0);
            chk("rst_err", 32'(rsp_err_v[d]), 32'd0);
        end
        rst_v = 3'b000;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rel_ready", 32'(req_ready_v[d]), 32'd1);
        end

        foreach (tbl[i]) begin
            model(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                  r, e, k);
            txn($sformatf("vec%0d", i), 0, tbl[i].we, tbl[i].f3,
                tbl[i].addr, tbl[i].wdata, 1'b0,
                tbl[i].rdata, tbl[i].err, 1'b1);
        end

        txn_m("ws3_pre", 1, 1, 3'b010, 32'h44, 32'h01020304, 0);
        txn_m("ws3_poke", 1, 1, 3'b010, 32'h40, 32'hCAFEF00D, 1);
        txn_m("ws3_ld44", 1, 0, 3'b010, 32'h44, 32'h0, 0);
        txn_m("ws3_ld40", 1, 0, 3'b010, 32'h40, 32'h0, 0);

        txn_m("ab_sw1", 2, 1, 3'b010, 32'h20, 32'h11111111, 0);
        txn_m("ab_lw1", 2, 0, 3'b010, 32'h20, 32'h0, 0);
        accept(2, 1, 3'b010, 32'h20, 32'h12345678);
        @(negedge clk);
        rst_v[2] = 1'b1;
        #1;
        chk("ab_rst_valid", 32'(rsp_valid_v[2]), 32'd0);
        chk("ab_rst_rdata", rdata_v[2], 32'd0);
        chk("ab_rst_err", 32'(rsp_err_v[2]), 32'd0);
        chk("ab_rst_ready", 32'(req_ready_v[2]), 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("ab_no_rsp", 32'(rsp_valid_v[2]), 32'd0);
        end
        rst_v[2] = 1'b0;
        #1;
        chk("ab_rel_ready", 32'(req_ready_v[2]), 32'd1);
        txn_m("ab_lw2", 2, 0, 3'b010, 32'h20, 32'h0, 0);
        txn_m("ab_sw0", 2, 1, 3'b010, 32'h20, 32'h0, 0);
        txn_m("ab_lw3", 2, 0, 3'b010, 32'h20, 32'h0, 0);

        accept(2, 0, 3'b010, 32'h20, 32'h0);
        repeat (3) @(negedge clk);
        chk("rr_valid_pre", 32'(rsp_valid_v[2]), 32'd1);
        rst_v[2] = 1'b1;
        #1;
        chk("rr_valid_drop", 32'(rsp_valid_v[2]), 32'd0);
        @(negedge clk);
        rst_v[2] = 1'b0;
        #1;
        chk("rr_ready", 32'(req_ready_v[2]), 32'd1);
        txn_m("rr_lw", 2, 0, 3'b010, 32'h20, 32'h0, 0);

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 8; w++) begin
                txn_m("init", d, 1, 3'b010, 32'h100 + 32'(4 * w),
                      $urandom, 0);
            end
            for (int n = 0; n < 40; n++) begin
                bit [31:0] a;
                a = ($urandom_range(0, 7) == 0) ? $urandom
                    : 32'h100 + 32'($urandom_range(0, 31));
                txn_m($sformatf("rnd%0d_%0d", d, n), d,
                      1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), a, $urandom, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
